// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and default sizing constants
package imem_loader_pkg;
  localparam int W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int HOLD_CYC_DEF = 4;
  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERR} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready instruction word stream (in_valid, in_word, in_last from master; in_ready from slave)
interface imem_loader_if
  import imem_loader_pkg::*;
#(parameter int W = W_DEF);
  logic in_valid;
  logic [W-1:0] in_word;
  logic in_last;
  logic in_ready;
  modport master(output in_valid, in_word, in_last, input in_ready);
  modport slave(input in_valid, in_word, in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writes stream src into imem from addr 0 (mem_we/mem_addr/mem_wdata), holds cpu_rst until done, flags err_overflow, counts word_count; IMEM_LOADER_CHECKSUM_EN adds checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
)(
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [W-1:0]      checksum
`endif
);
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
  state_t state;
  logic [7:0] hcnt;
  logic acc, fin;
  always_comb begin
    acc = state == LOAD && src.in_valid && src.in_ready;
    fin = acc && (src.in_last || word_count == LAST_PTR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      src.in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_rst <= 1'b1;
      done <= 1'b0;
      err_overflow <= 1'b0;
      word_count <= '0;
      hcnt <= '0;
    end else begin
      mem_we <= acc;
      src.in_ready <= state == LOAD && !fin;
      if (acc) begin
        mem_addr <= word_count[ADDR_W-1:0];
        mem_wdata <= src.in_word;
        word_count <= word_count + 1'b1;
      end
      case (state)
        LOAD: if (fin) begin
          state <= src.in_last ? HOLD : ERR;
          err_overflow <= !src.in_last;
          hcnt <= '0;
        end
        HOLD: if (hcnt == 8'(HOLD_CYC - 1)) begin
          state <= RUN;
          cpu_rst <= 1'b0;
          done <= 1'b1;
        end else hcnt <= hcnt + 1'b1;
        default: ;
      endcase
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) checksum <= '0;
    else if (acc) checksum <= checksum + src.in_word;
  end
`endif
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the five-stage pipeline processor. Accepts a stream of 16-bit instruction words over a valid/ready interface and writes them into instruction memory from address 0 upward. Holds the processor in reset until the final word is written, then releases it. It is the writer counterpart to the processor's instruction-fetch reader and replaces bench-side memory preloading.

## Interface
- W, 16, instruction word width (matches processor datapath width)
- ADDR_W, 10, instruction memory address width; DEPTH = 2**ADDR_W words
- HOLD_CYC, 4, cycles between the last write and processor reset release; legal range 1..255
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  source presents a word
- in_word  in  W  instruction word
- in_last  in  1  marks the final word of the program
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  W  write data
- cpu_rst  out  1  drives processor rst; high until load completes
- done  out  1  program loaded, processor running
- err_overflow  out  1  sticky; stream exceeded DEPTH words without in_last
- word_count  out  ADDR_W+1  words written since reset

## Operation
- States: LOAD, HOLD, RUN, ERR. Reset state: LOAD.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err_overflow=0, word_count=0, internal write pointer=0.
- LOAD: in_ready=1. A word is accepted when in_valid && in_ready. An accepted word is written at the current pointer; the pointer and word_count increment.
- Accepted with in_last=1 -> HOLD. in_ready drops.
- Accepted with pointer==DEPTH-1 and in_last=0 -> the word is written; go to ERR.
- Accepted with pointer==DEPTH-1 and in_last=1 -> normal completion to HOLD; no error.
- HOLD: the counter runs HOLD_CYC cycles, then the state goes to RUN.
- RUN: cpu_rst=0, done=1, in_ready=0. The state is terminal until rst.
- ERR: err_overflow=1, cpu_rst stays 1, in_ready=0. The state is terminal until rst.
- The pointer never wraps. in_valid while in_ready=0 is ignored; in_word and in_last are don't-care.
- An empty program is impossible. The first accepted word with in_last=1 is a one-word program.
- rst asserted in any state, including mid-load or mid-HOLD, returns all outputs to their reset values on that edge. Memory contents are not cleared. A subsequent load overwrites from address 0.

## Timing
- All outputs are registered.
- in_ready is 0 on the reset edge and 1 from the first edge after rst deasserts.
- Write latency is 1 cycle. A word accepted before edge E appears on mem_we/mem_addr/mem_wdata after E, for exactly one cycle.
- Throughput is one word per cycle. Back-to-back accepts give contiguous addresses.
- Let edge E be the edge that accepts the last word. Then:
  - in_ready=0 after E.
  - The last write is visible after E.
  - cpu_rst falls and done rises at edge E+HOLD_CYC.
- Overflow: err_overflow rises at the same edge that emits the DEPTH-th write.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds output port checksum (W bits, reset 0).
  - checksum is the mod-2^W sum of all accepted words, updated with the same 1-cycle latency as the write.
  - It is frozen in HOLD, RUN and ERR.
- Macro undefined: the port and its adder are absent. All other behaviour is identical.

## Structure
- Package imem_loader_pkg holds:
  - the state enum typedef (LOAD, HOLD, RUN, ERR);
  - the default constants for W, ADDR_W and HOLD_CYC.
- No sub-module. The hold counter and pointer are inline; a separate module adds no reuse value.

## Test plan
- Three-word load: words 0x1234, 0xABCD, 0x0F0F, continuous valid, last on the third word.
  - Writes land at addresses 0, 1, 2 on consecutive cycles.
  - word_count=3.
  - cpu_rst falls exactly 4 cycles after the accepting edge; done=1.
- Gapped stream: in_valid toggling 1,0,0,1,1 with 3 words.
  - Writes occur only on accepted cycles.
  - Addresses stay contiguous 0..2 and no duplicate writes occur.
- Overflow with ADDR_W=2: 5 words with no last.
  - 4 writes to addresses 0..3.
  - err_overflow=1 with the 4th write; 5th word not accepted (in_ready=0).
  - cpu_rst stays 1 and done=0.
- Exact fill with ADDR_W=2: 4 words, last on the 4th.
  - err_overflow=0 and done=1 after HOLD_CYC.
- Reset mid-load: rst pulsed after 2 of 5 words.
  - Outputs return to reset values; word_count=0.
  - Restarted 1-word load writes address 0, and done rises HOLD_CYC cycles later.
- With IMEM_LOADER_CHECKSUM_EN: words 0xFFFF, 0x0002.
  - checksum=0x0001 after the second write, unchanged through RUN.
